// File: rtl/fifo_drain_rr_pkg.sv
// fifo_drain_rr shared constants.
// State encoding and source ids.
package fifo_drain_rr_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/fifo_drain_rr_arb2.sv
// Two-request round-robin arbiter.
// Combinational one-hot grant, registered pointer.
module rr_arb2
  import fifo_drain_rr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // on contention favour the source not granted last
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (last_q == SRC_D1) ? 2'b01 : 2'b10;
    end
  end

  // pointer follows every grant
  always_comb begin
    last_d = last_q;
    if (|gnt_o) begin
      last_d = gnt_o[1];
    end
  end

  // pointer register; D0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_D1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_drain_rr.sv
// Round-robin drain of two upstream FIFOs
// into one downstream FIFO, halting on error.
module fifo_drain_rr
  import fifo_drain_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  empty_d0,
  input  logic                  empty_d1,
  input  logic [DATA_WIDTH-1:0] data_in_d0,
  input  logic [DATA_WIDTH-1:0] data_in_d1,
  input  logic                  error_d0,
  input  logic                  error_d1,
  input  logic                  full_down,
  input  logic                  almost_full_down,
  output logic                  rd_enable_d0,
  output logic                  rd_enable_d1,
  output logic                  wr_enable_down,
  output logic [DATA_WIDTH-1:0] data_out_down,
  output logic                  src_down,
  output logic                  idle,
  output logic                  error_out
);

  logic [1:0]            state_q, state_d;
  logic                  rd0_q, rd1_q;
  logic                  wr_q, src_q, err_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic       pend;
  logic       err_in;
  logic       space;
  logic       can_pop;
  logic [1:0] req;
  logic [1:0] gnt;

  assign pend   = rd0_q | rd1_q;
  assign err_in = error_d0 | error_d1;

  // the pending word is not yet in the downstream count
  assign space   = !full_down && !(pend && almost_full_down);
  assign can_pop = space && (state_q != ST_HALT) && !err_in;
  assign req     = {!empty_d1 && can_pop, !empty_d0 && can_pop};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset_L),
    .req_i (req),
    .gnt_o (gnt)
  );

  // select read data of the source popped last cycle
  always_comb begin
    data_d = '0;
    unique case (1'b1)
      rd1_q:   data_d = data_in_d1;
      rd0_q:   data_d = data_in_d0;
      default: data_d = '0;
    endcase
  end

  // IDLE/ACTIVE follow traffic; any error parks in HALT
  always_comb begin
    state_d = state_q;
    if (err_in) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE:   if (|req) state_d = ST_ACTIVE;
        ST_ACTIVE: if (!(|gnt) && !pend) state_d = ST_IDLE;
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // pop requests, forwarding stage and sticky error
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      rd0_q   <= 1'b0;
      rd1_q   <= 1'b0;
      wr_q    <= 1'b0;
      src_q   <= SRC_D0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd0_q   <= gnt[0];
      rd1_q   <= gnt[1];
      wr_q    <= pend;
      src_q   <= rd1_q ? SRC_D1 : SRC_D0;
      data_q  <= data_d;
      err_q   <= err_q | err_in;
    end
  end

  assign rd_enable_d0   = rd0_q;
  assign rd_enable_d1   = rd1_q;
  assign wr_enable_down = wr_q;
  assign data_out_down  = data_q;
  assign src_down       = src_q;
  assign idle           = (state_q == ST_IDLE);
  assign error_out      = err_q;

endmodule
